// File: rtl/if_id_skid_stage_if.sv
// Fetch-to-decode beat bundle: upstream handshake, downstream handshake, flush and stall counter.
// Lane 0 occupies the LSBs of every packed per-lane field.
interface if_id_skid_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned LANES  = 2,
   parameter int unsigned CNT_W  = 16
);
   logic                    flush_i;
   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [LANES-1:0]        in_lane_valid_i;
   logic [LANES*PC_W-1:0]   in_pc_i;
   logic [LANES*DATA_W-1:0] in_inst_i;
   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [LANES-1:0]        out_lane_valid_o;
   logic [LANES*PC_W-1:0]   out_pc_o;
   logic [LANES*DATA_W-1:0] out_inst_o;
   logic [CNT_W-1:0]        stall_cnt_o;

   modport slave (
      input  flush_i, in_valid_i, in_lane_valid_i, in_pc_i, in_inst_i, out_ready_i,
      output in_ready_o, out_valid_o, out_lane_valid_o, out_pc_o, out_inst_o, stall_cnt_o
   );

   modport master (
      output flush_i, in_valid_i, in_lane_valid_i, in_pc_i, in_inst_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_lane_valid_o, out_pc_o, out_inst_o, stall_cnt_o
   );
endinterface

// File: rtl/if_id_skid_stage.sv
// LANES-wide IF/ID pipeline stage with a 2-entry skid buffer, flush-to-NOP and a
// saturating stall-cycle counter. Outputs come straight from the MAIN register.
module if_id_skid_stage #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       PC_W     = 32,
   parameter int unsigned       LANES    = 2,
   parameter logic [DATA_W-1:0] NOP_INST = '0,
   parameter int unsigned       CNT_W    = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   if_id_skid_stage_if.slave port
);
   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

   state_t                  r_state;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic [LANES-1:0]        r_main_lv;
   logic [LANES*PC_W-1:0]   r_main_pc;
   logic [LANES*DATA_W-1:0] r_main_inst;
   logic [LANES-1:0]        r_skid_lv;
   logic [LANES*PC_W-1:0]   r_skid_pc;
   logic [LANES*DATA_W-1:0] r_skid_inst;
   logic [CNT_W-1:0]        r_stall_cnt;

   logic w_in_fire;
   logic w_out_fire;
   logic w_stall;

   assign w_in_fire  = port.in_valid_i & r_in_ready;
   assign w_out_fire = r_out_valid & port.out_ready_i;
   assign w_stall    = r_out_valid & ~port.out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || port.flush_i) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_main_lv   <= '0;
         r_main_pc   <= '0;
         r_main_inst <= {LANES{NOP_INST}};
         r_skid_lv   <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  r_main_lv   <= port.in_lane_valid_i;
                  r_main_pc   <= port.in_pc_i;
                  r_main_inst <= port.in_inst_i;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (w_in_fire && w_out_fire) begin
                  r_main_lv   <= port.in_lane_valid_i;
                  r_main_pc   <= port.in_pc_i;
                  r_main_inst <= port.in_inst_i;
               end else if (w_in_fire) begin
                  r_skid_lv   <= port.in_lane_valid_i;
                  r_skid_pc   <= port.in_pc_i;
                  r_skid_inst <= port.in_inst_i;
                  r_in_ready  <= 1'b0;
                  r_state     <= ST_SKID;
               end else if (w_out_fire) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (w_out_fire) begin
                  r_main_lv   <= r_skid_lv;
                  r_main_pc   <= r_skid_pc;
                  r_main_inst <= r_skid_inst;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_FULL;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_state     <= ST_EMPTY;
            end
         endcase
      end
   end

   // Flush deliberately leaves the counter alone; only reset clears it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign port.in_ready_o       = r_in_ready;
   assign port.out_valid_o      = r_out_valid;
   assign port.out_lane_valid_o = r_main_lv & {LANES{r_out_valid}};
   assign port.out_pc_o         = r_main_pc;
   assign port.out_inst_o       = r_main_inst;
   assign port.stall_cnt_o      = r_stall_cnt;

   a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (r_out_valid && !port.out_ready_i && !port.flush_i) |=> r_out_valid);
   a_ready_skid: assert property (@(posedge clk_i) disable iff (rst_i)
      (r_in_ready == (r_state != ST_SKID)));
endmodule
